// File: rtl/i2s_stream_sequencer.sv
// I2S sample sequencer: codec start-up timing, L/R tracking, filter handshake and per-channel TX buffering.
// Optional macro AUDIO_STATS_EN adds saturating overrun/timeout event counters.
module i2s_stream_sequencer #(
  parameter int STARTUP_CYCLES  = 1024,
  parameter int DISCARD_SAMPLES = 4,
  parameter int PRE_SHIFT       = 3,
  parameter int PROC_TIMEOUT    = 255
) (
  input  logic        lmmi_clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic        clear_i,
  output logic        conf_en_o,
  input  logic        rx_valid_i,
  input  logic [31:0] rx_data_i,
  input  logic        tx_req_i,
  output logic [31:0] tx_data_o,
  output logic        proc_start_o,
  output logic        proc_ch_o,
  output logic [23:0] proc_data_o,
  input  logic        proc_done_i,
  input  logic [23:0] proc_data_i,
  output logic        running_o,
  output logic        error_o
`ifdef AUDIO_STATS_EN
  ,
  output logic [15:0] overrun_cnt_o,
  output logic [15:0] timeout_cnt_o
`endif
);

  localparam int CNT_MAX = (STARTUP_CYCLES > PROC_TIMEOUT) ? STARTUP_CYCLES : PROC_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DISC_W  = (DISCARD_SAMPLES > 1) ? $clog2(DISCARD_SAMPLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_WAIT_RX,
    S_PROCESS
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DISC_W-1:0]  disc_q, disc_d;
  logic               start_d;
  logic               accept;
  logic               overrun;
  logic               timeout;
  logic               done_hit;
  logic               clr_all;
  logic               running;

  logic               proc_start_q;
  logic               proc_ch_q;
  logic [23:0]        proc_data_q;
  logic               rx_ch_q;
  logic               tx_ch_q;
  logic [31:0]        tx_data_q;
  logic               error_q;
  logic [23:0]        out_buf_q [2];
  logic [23:0]        tx_sel;
  logic signed [23:0] rx_sample;
  logic               unused_rx_hi;

  assign rx_sample    = rx_data_i[23:0];
  assign unused_rx_hi = ^rx_data_i[31:24];
  assign tx_sel       = out_buf_q[tx_ch_q];
  assign running      = (state_q == S_WAIT_RX) || (state_q == S_PROCESS);
  // Entering (or staying in) IDLE wipes the channel state; this overrides same-cycle writes.
  assign clr_all      = (state_d == S_IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    disc_d   = disc_q;
    start_d  = 1'b0;
    accept   = 1'b0;
    overrun  = 1'b0;
    timeout  = 1'b0;
    done_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_WARMUP;
          cnt_d   = '0;
          disc_d  = '0;
        end
      end
      S_WARMUP: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (cnt_q != CNT_W'(STARTUP_CYCLES)) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (DISCARD_SAMPLES == 0 && cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
            state_d = S_WAIT_RX;
          end
        end else if (rx_valid_i) begin
          disc_d = disc_q + DISC_W'(1);
          if (disc_q == DISC_W'(DISCARD_SAMPLES - 1)) begin
            state_d = S_WAIT_RX;
          end
        end
      end
      S_WAIT_RX: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (rx_valid_i) begin
          accept  = 1'b1;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = S_PROCESS;
        end
      end
      S_PROCESS: begin
        // A sample arriving while the filter is busy is lost; a same-cycle done still lands.
        overrun = rx_valid_i;
        if (proc_done_i) begin
          done_hit = 1'b1;
        end else if (cnt_q == CNT_W'(PROC_TIMEOUT - 1)) begin
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (proc_done_i || timeout) begin
          state_d = enable_i ? S_WAIT_RX : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      disc_q       <= '0;
      proc_start_q <= 1'b0;
      proc_ch_q    <= 1'b0;
      proc_data_q  <= '0;
      rx_ch_q      <= 1'b0;
      tx_ch_q      <= 1'b0;
      tx_data_q    <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      disc_q       <= disc_d;
      proc_start_q <= start_d;
      if (accept) begin
        proc_data_q <= rx_sample >>> PRE_SHIFT;
        proc_ch_q   <= rx_ch_q;
      end
      // Channel trackers follow every codec strobe so L/R stays aligned even for dropped samples.
      if (clr_all) begin
        rx_ch_q <= 1'b0;
      end else if (rx_valid_i && state_q != S_IDLE) begin
        rx_ch_q <= ~rx_ch_q;
      end
      if (clr_all) begin
        tx_ch_q <= 1'b0;
      end else if (tx_req_i && state_q != S_IDLE) begin
        tx_ch_q <= ~tx_ch_q;
      end
      if (tx_req_i) begin
        tx_data_q <= running ? {{8{tx_sel[23]}}, tx_sel} : '0;
      end
      if (overrun || timeout) begin
        error_q <= 1'b1;
      end else if (clear_i) begin
        error_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 2; i++) begin
        out_buf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clr_all) begin
          out_buf_q[i] <= '0;
        end else if ((done_hit || timeout) && proc_ch_q == 1'(i)) begin
          out_buf_q[i] <= done_hit ? proc_data_i : 24'd0;
        end
      end
    end
  end

`ifdef AUDIO_STATS_EN
  logic [15:0] ovr_cnt_q;
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ovr_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      if (clear_i) begin
        ovr_cnt_q <= {15'd0, overrun};
      end else if (overrun && ovr_cnt_q != 16'hFFFF) begin
        ovr_cnt_q <= ovr_cnt_q + 16'd1;
      end
      if (clear_i) begin
        tmo_cnt_q <= {15'd0, timeout};
      end else if (timeout && tmo_cnt_q != 16'hFFFF) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end
    end
  end

  assign overrun_cnt_o = ovr_cnt_q;
  assign timeout_cnt_o = tmo_cnt_q;
`endif

  assign conf_en_o    = (state_q != S_IDLE);
  assign running_o    = running;
  assign proc_start_o = proc_start_q;
  assign proc_ch_o    = proc_ch_q;
  assign proc_data_o  = proc_data_q;
  assign tx_data_o    = tx_data_q;
  assign error_o      = error_q;

endmodule
